tape_player: RTL

- Playback side of the cassette path: the cassette loader writes a tape image into the buffer; tape_player reads it back and serialises it as a pulse-width-coded square wave on `ear`.
- The core's `ear` input (port 0x80 bit 0 when reg80[1] is set) sees the same waveform a real cassette deck would produce.
- Sits between the tape buffer read port and the core's `ear` input.
- Gated by the cassette motor bit so ROM LOAD timing controls playback.

---
 rtl/tape_player.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/tape_player.sv
// tape_player: plays the tape buffer back as a pulse-width-coded ear waveform.
// Define TAPE_CHECKSUM_EN to append a mod-256 byte sum after the data.
module tape_player #(
  parameter int HALF0  = 140,
  parameter int HALF1  = 280,
  parameter int HALFS  = 420,
  parameter int LEADER = 768,
  parameter int AW     = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce,
  input  logic          start,
  input  logic          stop,
  input  logic          motor,
  input  logic [AW-1:0] length,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [7:0]    mem_data,
  output logic          ear,
  output logic          busy,
  output logic          done
);
  localparam int PW = 16;
  localparam int LW = $clog2(LEADER + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEADER,
    S_SYNC,
    S_FETCH,
    S_LATCH,
    S_BIT_HI,
    S_BIT_LO,
    S_END
  } state_t;

  state_t        state;
  logic [AW-1:0] len_r;
  logic [PW-1:0] phase;
  logic [PW-1:0] half;
  logic [LW-1:0] lcnt;
  logic [7:0]    shreg;
  logic [2:0]    bidx;
  logic [AW-1:0] addr_nx;
  logic          tick;
  logic          last;
`ifdef TAPE_CHECKSUM_EN
  logic [7:0]    sum;
  logic          ck;
`endif

  always_comb begin
    half = PW'(HALF0);
    unique case (state)
      S_SYNC:   half = PW'(HALFS);
      S_BIT_HI,
      S_BIT_LO: if (shreg[7]) half = PW'(HALF1);
      default:  ;
    endcase
  end

  assign tick    = ce & motor;
  assign last    = (phase == half - PW'(1));
  assign addr_nx = mem_addr + AW'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      len_r    <= '0;
      phase    <= '0;
      lcnt     <= '0;
      shreg    <= '0;
      bidx     <= '0;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      ear      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef TAPE_CHECKSUM_EN
      sum      <= '0;
      ck       <= 1'b0;
`endif
    end else begin
      mem_rd <= 1'b0;
      done   <= 1'b0;
      if (stop) begin
        state <= S_IDLE;
        ear   <= 1'b0;
        busy  <= 1'b0;
        phase <= '0;
      end else begin
        unique case (state)
          S_IDLE: if (start) begin
            len_r    <= length;
            mem_addr <= '0;
            busy     <= 1'b1;
            lcnt     <= '0;
            phase    <= '0;
            ear      <= 1'b1;
            state    <= S_LEADER;
`ifdef TAPE_CHECKSUM_EN
            sum      <= '0;
            ck       <= 1'b0;
`endif
          end
          S_FETCH: state <= S_LATCH;
          S_LATCH: begin
            shreg <= mem_data;
            bidx  <= 3'd7;
            phase <= '0;
            ear   <= 1'b1;
            state <= S_BIT_HI;
`ifdef TAPE_CHECKSUM_EN
            sum   <= sum + mem_data;
`endif
          end
          S_END: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            ear   <= 1'b0;
            state <= S_IDLE;
          end
          default: if (tick) begin
            if (!last) begin
              phase <= phase + PW'(1);
            end else begin
              phase <= '0;
              if (ear) begin
                ear <= 1'b0;
                if (state == S_BIT_HI) state <= S_BIT_LO;
              end else begin
                // next cycle starts high unless the run ends here
                ear <= 1'b1;
                unique case (state)
                  S_LEADER: begin
                    lcnt <= lcnt + LW'(1);
                    if (lcnt == LW'(LEADER - 1)) state <= S_SYNC;
                  end
                  S_SYNC: begin
                    if (len_r == '0) begin
`ifdef TAPE_CHECKSUM_EN
                      shreg <= sum;
                      bidx  <= 3'd7;
                      ck    <= 1'b1;
                      state <= S_BIT_HI;
`else
                      ear   <= 1'b0;
                      state <= S_END;
`endif
                    end else begin
                      mem_rd <= 1'b1;
                      state  <= S_FETCH;
                    end
                  end
                  S_BIT_LO: begin
                    if (bidx != 3'd0) begin
                      shreg <= shreg << 1;
                      bidx  <= bidx - 3'd1;
                      state <= S_BIT_HI;
`ifdef TAPE_CHECKSUM_EN
                    end else if (ck) begin
                      ear   <= 1'b0;
                      state <= S_END;
`endif
                    end else begin
                      mem_addr <= addr_nx;
                      if (addr_nx == len_r) begin
`ifdef TAPE_CHECKSUM_EN
                        // sum is already final: last byte added at LATCH
                        shreg <= sum;
                        bidx  <= 3'd7;
                        ck    <= 1'b1;
                        state <= S_BIT_HI;
`else
                        ear   <= 1'b0;
                        state <= S_END;
`endif
                      end else begin
                        mem_rd <= 1'b1;
                        state  <= S_FETCH;
                      end
                    end
                  end
                  default: ;
                endcase
              end
            end
          end
        endcase
      end
    end
  end
endmodule
